cv32e40px_apu_arbiter: RTL and testbench
========================================

# cv32e40px_apu_arbiter

Shares one APU/FPU datapath instance (fpnew behind the core's FP wrapper) between `NUM_REQ` APU master ports, e.g. several cores or harts of a cluster. It selects one requester per cycle with round-robin priority and forwards its operands, op and flags to the FPU. It records the issuing requester in an in-order ID FIFO and routes each FPU response back to the requester that issued it. It sits between the cores' APU master ports and the single FPU wrapper's request/response channels.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requester ports; must be ≥ 2.
- `MAX_OUTSTANDING`, 4: ID FIFO depth, i.e. maximum issued-but-unanswered operations; must be ≥ 1.
- `IDW`, `$clog2(NUM_REQ)`: requester index width (derived).

Ports:
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `req_apu_req_i`  in  [NUM_REQ]  per-requester request valid.
- `req_apu_gnt_o`  out  [NUM_REQ]  per-requester grant; one-hot or zero.
- `req_apu_operands_i`  in  [NUM_REQ][APU_NARGS_CPU][32]  operands.
- `req_apu_op_i`  in  [NUM_REQ][APU_WOP_CPU]  op code.
- `req_apu_flags_i`  in  [NUM_REQ][APU_NDSFLAGS_CPU]  format and round-mode flags.
- `req_apu_rvalid_o`  out  [NUM_REQ]  response valid; one-hot or zero.
- `req_apu_rdata_o`  out  [NUM_REQ][32]  result; zero on non-selected ports.
- `req_apu_rflags_o`  out  [NUM_REQ][APU_NUSFLAGS_CPU]  status flags; zero on non-selected ports.
- `fpu_req_o`  out  1  request to FPU.
- `fpu_gnt_i`  in  1  FPU ready.
- `fpu_operands_o`, `fpu_op_o`, `fpu_flags_o`  out  same widths as one requester  muxed request payload.
- `fpu_rvalid_i`, `fpu_rdata_i` [32], `fpu_rflags_i` [APU_NUSFLAGS_CPU]  in  FPU response; there is no backpressure on responses.
- `outstanding_o`  out  [$clog2(MAX_OUTSTANDING+1)]  current FIFO occupancy.
- `err_o`  out  1  sticky spurious-response flag.

## Operation
- **Requester protocol:** once `req_apu_req_i[i]` is asserted, its payload is held stable until `req_apu_gnt_o[i]`.
- **Selection:** `sel` is the first index with `req_apu_req_i` high, searching from `rr_ptr` upward and wrapping modulo `NUM_REQ`.
- **Request forwarding:**
  - `fpu_req_o = |req_apu_req_i && !full`, where `full = (count == MAX_OUTSTANDING)`.
  - The payload outputs carry requester `sel`'s payload when any request is pending, and zero otherwise.
- **Issue:** an issue occurs when `fpu_req_o && fpu_gnt_i`.
  - On issue, `req_apu_gnt_o[sel] = 1` combinationally; all other grants are 0.
  - `sel` is pushed into the ID FIFO.
  - `rr_ptr <= (sel == NUM_REQ-1) ? 0 : sel+1`.
  - Without an issue, `rr_ptr` holds.
- **Full:** issue is blocked when `full`, even if a response pops in the same cycle. There is no full-bypass.
- **Response routing:**
  - On `fpu_rvalid_i` with count > 0: pop the head, drive `req_apu_rvalid_o[head] = 1`, and route `fpu_rdata_i` and `fpu_rflags_i` to port `head`.
  - Response routing is combinational, zero-cycle.
- **Spurious response:** on `fpu_rvalid_i` with count == 0, nothing is routed, nothing is popped, and `err_o <= 1`. `err_o` clears only on reset.
- **Simultaneous issue and pop:** count is unchanged, and both FIFO pointers advance.
- **Occupancy and pointers:**
  - `count` ranges 0..MAX_OUTSTANDING.
  - Read and write pointers wrap modulo `MAX_OUTSTANDING`, including for non-power-of-two depths.
  - `outstanding_o = count`.
- **Ordering:** the FPU behind this block is configured with equal pipeline latency across all operation groups and returns results in issue order. The arbiter relies on this ordering.
- **Reset:**
  - Async assertion clears `rr_ptr`, `count`, the FIFO pointers and `err_o` immediately.
  - Operations in flight are discarded. Their later responses are treated as spurious and set `err_o`.
  - The FPU is reset from the same source.

## Timing
- Grant latency: 0 cycles from request when the FPU is ready, not full and the requester wins.
- Response latency added by the arbiter: 0 cycles.
- Values while reset is active: all `*_gnt_o`, `*_rvalid_o`, `*_rdata_o` and `*_rflags_o` are 0; `fpu_req_o` = 0, `fpu_operands_o` / `fpu_op_o` / `fpu_flags_o` = 0, `outstanding_o` = 0, `err_o` = 0.
- Throughput: 1 issue per cycle and 1 response per cycle, concurrently.
- No combinational path from `fpu_rvalid_i` to `fpu_req_o`. The full check uses registered `count` only.

## Test plan
- **Single requester:** port 1 requests A = 0x3F800000, B = 0x40000000 (FADD), FPU latency 2 → `req_apu_gnt_o` = 2'b10 in cycle 0. In cycle 2, `req_apu_rvalid_o` = 2'b10 and `req_apu_rdata_o[1]` = 0x40400000; port 0 outputs stay zero.
- **Round robin:** both ports request continuously for 6 cycles with `fpu_gnt_i` = 1 → grants go 0, 1, 0, 1, 0, 1, and responses return to ports in the same order.
- **Full backpressure:** MAX_OUTSTANDING = 4, FPU latency 10, port 0 requesting continuously → 4 grants, then `fpu_req_o` = 0 and `outstanding_o` = 4. The first response frees a slot, and the next grant comes one cycle after that response.
- **FPU stall:** `fpu_gnt_i` = 0 for 3 cycles with both ports requesting → no grants, `rr_ptr` unchanged, payload held. On release, the port pointed to by `rr_ptr` wins.
- **Simultaneous issue and pop at count = 3:** `outstanding_o` stays 3, and the routed ID equals the oldest pushed ID.
- **Spurious response and reset:** `fpu_rvalid_i` pulsed with count = 0 → all `req_apu_rvalid_o` = 0 and `err_o` = 1 next cycle. Then `rst_i` asserted with 2 operations in flight → `outstanding_o` = 0 and `err_o` = 0 immediately.

Source files
------------

// File: rtl/cv32e40px_apu_arbiter_if.sv
// APU request/response bus with N parallel ports. The requester side drives
// req and payload. The FPU side answers with gnt and the response channel.
interface cv32e40px_apu_arbiter_if #(
  parameter int N        = 1,
  parameter int NARGS    = 3,
  parameter int WOP      = 6,
  parameter int NDSFLAGS = 15,
  parameter int NUSFLAGS = 5
);
  logic [N-1:0]                       req;
  logic [N-1:0]                       gnt;
  logic [N-1:0][NARGS-1:0][31:0]      operands;
  logic [N-1:0][WOP-1:0]              op;
  logic [N-1:0][NDSFLAGS-1:0]         flags;
  logic [N-1:0]                       rvalid;
  logic [N-1:0][31:0]                 rdata;
  logic [N-1:0][NUSFLAGS-1:0]         rflags;

  modport master (output req, operands, op, flags,
                  input  gnt, rvalid, rdata, rflags);
  modport slave  (input  req, operands, op, flags,
                  output gnt, rvalid, rdata, rflags);
endinterface

// File: rtl/cv32e40px_apu_arbiter.sv
// Round-robin sharing of one FPU between NUM_REQ APU masters. An in-order ID
// FIFO routes each FPU response back to the requester that issued it.
module cv32e40px_apu_arbiter #(
  parameter int NUM_REQ          = 2,
  parameter int MAX_OUTSTANDING  = 4,
  parameter int APU_NARGS_CPU    = 3,
  parameter int APU_WOP_CPU      = 6,
  parameter int APU_NDSFLAGS_CPU = 15,
  parameter int APU_NUSFLAGS_CPU = 5,
  localparam int CW = $clog2(MAX_OUTSTANDING+1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  cv32e40px_apu_arbiter_if.slave  req_apu,
  cv32e40px_apu_arbiter_if.master fpu,
  output logic [CW-1:0]          outstanding_o,
  output logic                   err_o
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [IDW-1:0] rr_q, rr_d, sel, head;
  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  wptr_q, rptr_q;
  logic [MAX_OUTSTANDING-1:0][IDW-1:0] ids_q;
  logic           err_q;
  logic           any_req, full, issue, pop, spur;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING-1)) ? '0 : p + 1'b1;
  endfunction

  // First requester at or after rr_q, wrapping.
  always_comb begin
    int idx;
    sel     = rr_q;
    any_req = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_req && req_apu.req[idx]) begin
        sel     = IDW'(idx);
        any_req = 1'b1;
      end
    end
  end

  // Full uses registered count only; a same-cycle pop never unblocks issue.
  assign full  = (count_q == CW'(MAX_OUTSTANDING));
  assign issue = fpu.req[0] && fpu.gnt[0];
  assign head  = ids_q[rptr_q];
  assign pop   = fpu.rvalid[0] && (count_q != '0);
  assign spur  = fpu.rvalid[0] && (count_q == '0);

  always_comb begin
    fpu.req[0]      = any_req && !full && !rst_i;
    fpu.operands[0] = '0;
    fpu.op[0]       = '0;
    fpu.flags[0]    = '0;
    if (any_req && !rst_i) begin
      fpu.operands[0] = req_apu.operands[sel];
      fpu.op[0]       = req_apu.op[sel];
      fpu.flags[0]    = req_apu.flags[sel];
    end
  end

  always_comb begin
    logic hit;
    for (int i = 0; i < NUM_REQ; i++) begin
      hit                = pop && (head == IDW'(i));
      req_apu.gnt[i]     = issue && (sel == IDW'(i));
      req_apu.rvalid[i]  = hit;
      req_apu.rdata[i]   = hit ? fpu.rdata[0]  : '0;
      req_apu.rflags[i]  = hit ? fpu.rflags[0] : '0;
    end
  end

  always_comb begin
    rr_d    = rr_q;
    count_d = count_q;
    if (issue) rr_d = (sel == IDW'(NUM_REQ-1)) ? '0 : sel + 1'b1;
    if (issue && !pop)      count_d = count_q + 1'b1;
    else if (pop && !issue) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q    <= '0;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      ids_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      rr_q    <= rr_d;
      count_q <= count_d;
      if (issue) begin
        ids_q[wptr_q] <= sel;
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (pop)  rptr_q <= ptr_inc(rptr_q);
      if (spur) err_q  <= 1'b1;
    end
  end

  assign outstanding_o = count_q;
  assign err_o         = err_q;
endmodule

// File: tb/tb_cv32e40px_apu_arbiter.sv
// Randomized and directed bench for the APU arbiter against a queue-based model.
module tb_cv32e40px_apu_arbiter;
  localparam int N = 2, MAXO = 4, NARGS = 3, WOP = 6, NDS = 15, NUS = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cv32e40px_apu_arbiter_if #(.N(N), .NARGS(NARGS), .WOP(WOP), .NDSFLAGS(NDS), .NUSFLAGS(NUS)) rq();
  cv32e40px_apu_arbiter_if #(.N(1), .NARGS(NARGS), .WOP(WOP), .NDSFLAGS(NDS), .NUSFLAGS(NUS)) fp();
  logic [$clog2(MAXO+1)-1:0] outstanding;
  logic err;

  cv32e40px_apu_arbiter #(
    .NUM_REQ(N), .MAX_OUTSTANDING(MAXO), .APU_NARGS_CPU(NARGS), .APU_WOP_CPU(WOP),
    .APU_NDSFLAGS_CPU(NDS), .APU_NUSFLAGS_CPU(NUS)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_apu(rq), .fpu(fp),
    .outstanding_o(outstanding), .err_o(err)
  );

  int checks = 0, fails = 0;

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: round-robin pointer, owner queue, sticky error.
  int rr_m = 0;
  int own_q[$];
  bit err_m = 1'b0;

  typedef struct { int due; logic [31:0] d; logic [NUS-1:0] f; } rsp_t;
  rsp_t rsp_q[$];

  int cyc_n = 0, lat = 2;
  bit rnd = 1'b0, spur = 1'b0, use_ovr = 1'b0;
  bit [N-1:0] cont = '0;
  logic [31:0] ovr = '0;
  logic [N-1:0] o_gnt, o_rv;
  logic [N-1:0][31:0] o_rd;
  logic o_freq;

  task automatic newp(int i);
    rq.operands[i] = {$urandom, $urandom, $urandom};
    rq.op[i]       = WOP'($urandom);
    rq.flags[i]    = NDS'($urandom);
  endtask

  task automatic cyc();
    int sel;
    bit any, freq, iss, pop, spr;
    logic [N-1:0] eg, erv;
    logic [N-1:0][31:0] erd;
    logic [N-1:0][NUS-1:0] erf;
    fp.rvalid = '0; fp.rdata = '0; fp.rflags = '0;
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc_n) begin
      fp.rvalid = 1'b1; fp.rdata[0] = rsp_q[0].d; fp.rflags[0] = rsp_q[0].f;
      rsp_q.delete(0);
    end else if (spur) begin
      fp.rvalid = 1'b1; fp.rdata[0] = $urandom; fp.rflags[0] = NUS'($urandom);
    end
    @(negedge clk);
    any = |rq.req; sel = 0;
    for (int k = 0; k < N; k++)
      if (rq.req[(rr_m + k) % N]) begin sel = (rr_m + k) % N; break; end
    freq = any && own_q.size() < MAXO;
    iss  = freq && fp.gnt[0];
    pop  = fp.rvalid[0] && own_q.size() > 0;
    spr  = fp.rvalid[0] && own_q.size() == 0;
    eg = '0; erv = '0; erd = '0; erf = '0;
    if (iss) eg[sel] = 1'b1;
    if (pop) begin
      erv[own_q[0]] = 1'b1; erd[own_q[0]] = fp.rdata[0]; erf[own_q[0]] = fp.rflags[0];
    end
    chk("gnt", rq.gnt, eg);
    chk("fpu_req", fp.req, freq);
    chk("operands", fp.operands, any ? rq.operands[sel] : '0);
    chk("op", fp.op, any ? rq.op[sel] : '0);
    chk("flags", fp.flags, any ? rq.flags[sel] : '0);
    chk("rvalid", rq.rvalid, erv);
    chk("rdata", rq.rdata, erd);
    chk("rflags", rq.rflags, erf);
    o_gnt = rq.gnt; o_rv = rq.rvalid; o_rd = rq.rdata; o_freq = fp.req[0];
    @(posedge clk); #1;
    if (pop) own_q.delete(0);
    if (iss) begin
      own_q.push_back(sel);
      rr_m = (sel + 1) % N;
      rsp_q.push_back('{due: cyc_n + lat,
                        d: use_ovr ? ovr : rq.operands[sel][0] + rq.operands[sel][1],
                        f: NUS'(rq.op[sel]) ^ rq.flags[sel][NUS-1:0]});
    end
    if (spr) err_m = 1'b1;
    cyc_n++;
    chk("outstanding", outstanding, own_q.size());
    chk("err", err, err_m);
    for (int i = 0; i < N; i++) begin
      if (o_gnt[i]) begin
        if (cont[i]) newp(i); else rq.req[i] = 1'b0;
      end else if (rnd && !rq.req[i] && $urandom_range(0, 99) < 50) begin
        rq.req[i] = 1'b1; newp(i);
      end
    end
  endtask

  task automatic do_reset(bit keep_rsp);
    rst = 1'b1;
    rq.req = '1; fp.gnt = 1'b1; fp.rvalid = 1'b1; fp.rdata = '1; fp.rflags = '1;
    #12;
    chk("rst_gnt", rq.gnt, 0);
    chk("rst_fpu_req", fp.req, 0);
    chk("rst_payload", {fp.operands, fp.op, fp.flags}, 0);
    chk("rst_rvalid", rq.rvalid, 0);
    chk("rst_rdata", {rq.rdata, rq.rflags}, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err, 0);
    rq.req = '0; fp.gnt = 1'b0; fp.rvalid = '0; fp.rdata = '0; fp.rflags = '0;
    rr_m = 0; own_q.delete(); err_m = 1'b0;
    if (!keep_rsp) rsp_q.delete();
    cont = '0; rnd = 1'b0; spur = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) newp(i);
    rq.req = '0; fp.gnt = 1'b0; fp.rvalid = '0; fp.rdata = '0; fp.rflags = '0;
    do_reset(0);

    // Single requester, FADD 1.0 + 2.0, latency 2
    lat = 2; use_ovr = 1'b1; ovr = 32'h40400000; fp.gnt = 1'b1;
    rq.req = 2'b10; rq.operands[1] = {32'h0, 32'h40000000, 32'h3F800000}; rq.op[1] = '0;
    cyc(); chk("single_gnt", o_gnt, 2'b10);
    cyc(); cyc();
    chk("single_rv", o_rv, 2'b10);
    chk("single_rd1", o_rd[1], 32'h40400000);
    chk("single_rd0", o_rd[0], 0);
    use_ovr = 1'b0;

    // Round robin with both ports continuously requesting
    do_reset(0);
    lat = 3; cont = '1; rq.req = '1; fp.gnt = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k == 6) begin rq.req = '0; cont = '0; end
      cyc();
      if (k < 6)  chk("rr_gnt", o_gnt, (k % 2) ? 2'b10 : 2'b01);
      if (k >= 3) chk("rr_rv", o_rv, ((k - 3) % 2) ? 2'b10 : 2'b01);
    end

    // Full backpressure, latency 10
    do_reset(0);
    lat = 10; cont = 2'b01; rq.req = 2'b01; fp.gnt = 1'b1;
    for (int k = 0; k < 13; k++) begin
      cyc();
      if (k < 4) chk("full_gnt", o_gnt, 2'b01);
      else if (k <= 10) begin chk("full_blk", o_gnt, 0); chk("full_req", o_freq, 0); end
      else if (k == 11) chk("full_regrant", o_gnt, 2'b01);
      if (k == 6) chk("full_out", outstanding, 4);
    end
    rq.req = '0; cont = '0;
    for (int k = 0; k < 12; k++) cyc();

    // FPU stall keeps the round-robin pointer
    do_reset(0);
    lat = 4; fp.gnt = 1'b1; rq.req = 2'b01;
    cyc();
    newp(0); rq.req = '1; cont = '1; fp.gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin cyc(); chk("stall_gnt", o_gnt, 0); end
    fp.gnt = 1'b1;
    cyc(); chk("stall_win", o_gnt, 2'b10);

    // Simultaneous issue and pop at count 3
    do_reset(0);
    lat = 3; rq.req = '1; cont = '1; fp.gnt = 1'b1;
    for (int k = 0; k < 4; k++) cyc();
    chk("sim_out", outstanding, 3);
    chk("sim_rv", o_rv, 2'b01);

    // Spurious response, then async reset with operations in flight
    do_reset(0);
    spur = 1'b1; cyc(); spur = 1'b0;
    chk("spur_rv", o_rv, 0);
    chk("spur_err", err, 1);
    lat = 20; rq.req = 2'b11; fp.gnt = 1'b1;
    cyc(); cyc();
    chk("inflight_out", outstanding, 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_out", outstanding, 0);
    chk("arst_err", err, 0);
    do_reset(1);
    for (int k = 0; k < 25; k++) cyc();
    chk("late_err", err, 1);

    // Randomized traffic in blocks of fixed latency
    do_reset(0);
    for (int b = 0; b < 40; b++) begin
      lat = $urandom_range(1, 8);
      rnd = 1'b1;
      for (int c = 0; c < 50; c++) begin
        fp.gnt = ($urandom_range(0, 3) != 0);
        cyc();
      end
      fp.gnt = 1'b0;
      for (int c = 0; c < 20 && rsp_q.size() > 0; c++) cyc();
      chk("drain", rsp_q.size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
